// File: rtl/latency_mon_pkg.sv
// Shared types and the saturate-or-wrap adder for the latency monitor.
// The adder works on a fixed 64-bit carrier so every instance can share it whatever its W.
package latency_mon_pkg;

    localparam int unsigned DEF_W     = 32'd32;
    localparam int unsigned DEF_P     = 32'd8;
    localparam int unsigned SUM_W_MAX = 32'd64;

    typedef logic [DEF_W-1:0]     stat_t;
    typedef logic [DEF_P-1:0]     pend_t;
    typedef logic [SUM_W_MAX-1:0] sum_t;

    // Adds a and b within a w-bit field: clamps to all-ones when sat, else keeps the low w bits.
    function automatic sum_t sat_add(input sum_t a, input sum_t b, input int unsigned w, input logic sat);
        logic [SUM_W_MAX:0] full;
        logic [SUM_W_MAX:0] lim;
        full = {1'b0, a} + {1'b0, b};
        lim  = ({{SUM_W_MAX{1'b0}}, 1'b1} << w) - {{SUM_W_MAX{1'b0}}, 1'b1};
        if (sat && (full > lim)) begin
            return lim[SUM_W_MAX-1:0];
        end else begin
            return full[SUM_W_MAX-1:0] & lim[SUM_W_MAX-1:0];
        end
    endfunction

endpackage

// File: rtl/latency_mon_chan.sv
// One channel of the latency monitor: outstanding count, high-water mark,
// issue/retire/aggregate statistics and the sticky overflow/underflow flags.
module latency_mon_chan
    import latency_mon_pkg::*;
#(
    parameter int unsigned W   = 32'd32,
    parameter int unsigned P   = 32'd8,
    parameter bit          SAT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_issue,
    input  logic         i_retire,
    input  logic         i_clear,
    input  logic         i_freeze,
    output logic [P-1:0] o_pending_r,
    output logic [P-1:0] o_hwm_r,
    output logic [W-1:0] o_issue_cnt_r,
    output logic [W-1:0] o_retire_cnt_r,
    output logic [W-1:0] o_aggregate_cnt_r,
    output logic         o_err_ovf_r,
    output logic         o_err_udf_r
);

    typedef logic [W-1:0] stat_t;
    typedef logic [P-1:0] pend_t;

    pend_t r_pending;
    pend_t r_hwm;
    stat_t r_issue_cnt;
    stat_t r_retire_cnt;
    stat_t r_aggregate_cnt;
    logic  r_err_ovf;
    logic  r_err_udf;

    logic  w_at_max;
    logic  w_iss_ok;
    logic  w_ret_ok;
    pend_t w_pending_nxt;
    pend_t w_hwm_nxt;
    stat_t w_issue_sum;
    stat_t w_retire_sum;
    stat_t w_aggregate_sum;

    // Accept/reject each strobe and form next-state values; a retire may consume a same-cycle issue.
    always_comb begin
        w_at_max      = (r_pending == {P{1'b1}});
        w_iss_ok      = i_issue & ~(w_at_max & ~i_retire);
        w_ret_ok      = i_retire & ((r_pending != {P{1'b0}}) | i_issue);
        w_pending_nxt = r_pending + pend_t'(w_iss_ok) - pend_t'(w_ret_ok);
        if (w_pending_nxt > r_hwm) begin
            w_hwm_nxt = w_pending_nxt;
        end else begin
            w_hwm_nxt = r_hwm;
        end
        w_issue_sum     = stat_t'(sat_add(sum_t'(r_issue_cnt), sum_t'(w_iss_ok), W, SAT));
        w_retire_sum    = stat_t'(sat_add(sum_t'(r_retire_cnt), sum_t'(w_ret_ok), W, SAT));
        w_aggregate_sum = stat_t'(sat_add(sum_t'(r_aggregate_cnt), sum_t'(w_pending_nxt), W, SAT));
    end

    // Outstanding tracking keeps running through freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= {P{1'b0}};
            r_hwm     <= {P{1'b0}};
        end else if (i_clear) begin
            r_pending <= {P{1'b0}};
            r_hwm     <= {P{1'b0}};
        end else begin
            r_pending <= w_pending_nxt;
            r_hwm     <= w_hwm_nxt;
        end
    end

    // Issue counter, enabled only on an accepted issue outside freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt <= {W{1'b0}};
        end else if (i_clear) begin
            r_issue_cnt <= {W{1'b0}};
        end else if (!i_freeze && w_iss_ok) begin
            r_issue_cnt <= w_issue_sum;
        end
    end

    // Retire counter, enabled only on an accepted retire outside freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= {W{1'b0}};
        end else if (i_clear) begin
            r_retire_cnt <= {W{1'b0}};
        end else if (!i_freeze && w_ret_ok) begin
            r_retire_cnt <= w_retire_sum;
        end
    end

    // Occupancy integral; idle cycles add nothing so the flop stays disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aggregate_cnt <= {W{1'b0}};
        end else if (i_clear) begin
            r_aggregate_cnt <= {W{1'b0}};
        end else if (!i_freeze && (w_pending_nxt != {P{1'b0}})) begin
            r_aggregate_cnt <= w_aggregate_sum;
        end
    end

    // Sticky error flags, released only by reset or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else if (i_clear) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            r_err_ovf <= r_err_ovf | (i_issue & ~w_iss_ok);
            r_err_udf <= r_err_udf | (i_retire & ~w_ret_ok);
        end
    end

    assign o_pending_r       = r_pending;
    assign o_hwm_r           = r_hwm;
    assign o_issue_cnt_r     = r_issue_cnt;
    assign o_retire_cnt_r    = r_retire_cnt;
    assign o_aggregate_cnt_r = r_aggregate_cnt;
    assign o_err_ovf_r       = r_err_ovf;
    assign o_err_udf_r       = r_err_udf;

endmodule

// File: rtl/latency_mon.sv
// Multi-channel issue/retire latency monitor: N_CH independent channels sharing
// clear and freeze, plus a busy summary taken straight from the pending flops.
module latency_mon
    import latency_mon_pkg::*;
#(
    parameter int unsigned W    = 32'd32,
    parameter int unsigned N_CH = 32'd4,
    parameter int unsigned P    = 32'd8,
    parameter bit          SAT  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CH-1:0]            issue,
    input  logic [N_CH-1:0]            retire,
    input  logic                       clear,
    input  logic                       freeze,
    output logic [N_CH-1:0][P-1:0]     pending_r,
    output logic [N_CH-1:0][W-1:0]     issue_cnt_r,
    output logic [N_CH-1:0][W-1:0]     retire_cnt_r,
    output logic [N_CH-1:0][W-1:0]     aggregate_cnt_r,
    output logic [N_CH-1:0][P-1:0]     hwm_r,
    output logic [N_CH-1:0]            err_ovf_r,
    output logic [N_CH-1:0]            err_udf_r,
    output logic                       busy
);

    logic w_busy;

    if ((P > W) || (W > SUM_W_MAX) || (N_CH < 32'd1) || (N_CH > 32'd32)) begin : g_bad_params
        $error("latency_mon: unsupported parameters W=%0d P=%0d N_CH=%0d", W, P, N_CH);
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        latency_mon_chan #(
            .W   (W),
            .P   (P),
            .SAT (SAT)
        ) u_chan (
            .clk               (clk),
            .rst_n             (rst_n),
            .i_issue           (issue[c]),
            .i_retire          (retire[c]),
            .i_clear           (clear),
            .i_freeze          (freeze),
            .o_pending_r       (pending_r[c]),
            .o_hwm_r           (hwm_r[c]),
            .o_issue_cnt_r     (issue_cnt_r[c]),
            .o_retire_cnt_r    (retire_cnt_r[c]),
            .o_aggregate_cnt_r (aggregate_cnt_r[c]),
            .o_err_ovf_r       (err_ovf_r[c]),
            .o_err_udf_r       (err_udf_r[c])
        );
    end

    // Busy while any channel has something outstanding.
    always_comb begin
        w_busy = 1'b0;
        for (int c = 0; c < int'(N_CH); c++) begin
            w_busy = w_busy | (pending_r[c] != {P{1'b0}});
        end
    end

    assign busy = w_busy;

endmodule

// File: tb/tb_latency_mon.sv
// Self-checking bench for latency_mon: three configurations share one stimulus stream
// and are compared every cycle against an arithmetic reference model.
module tb_latency_mon;

    localparam int ND = 3;
    localparam int NF = 7;
    localparam int F_PEND = 0, F_ICNT = 1, F_RCNT = 2, F_AGG = 3, F_HWM = 4, F_OVF = 5, F_UDF = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] issue, retire;
    logic       clear, freeze;

    logic [1:0][3:0] a_pend, a_hwm;
    logic [1:0][7:0] a_icnt, a_rcnt, a_agg;
    logic [1:0]      a_ovf, a_udf;
    logic            a_busy;
    logic [1:0][1:0] b_pend, b_hwm, c_pend, c_hwm;
    logic [1:0][3:0] b_icnt, b_rcnt, b_agg, c_icnt, c_rcnt, c_agg;
    logic [1:0]      b_ovf, b_udf, c_ovf, c_udf;
    logic            b_busy, c_busy;

    int cfg_w[ND]   = '{8, 4, 4};
    int cfg_p[ND]   = '{4, 2, 2};
    int cfg_sat[ND] = '{1, 0, 1};
    string fname[NF] = '{"pending", "issue_cnt", "retire_cnt", "aggregate", "hwm", "err_ovf", "err_udf"};

    longint mdl[ND][NF][2];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    latency_mon #(.W(8), .N_CH(2), .P(4), .SAT(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .issue(issue), .retire(retire), .clear(clear), .freeze(freeze),
        .pending_r(a_pend), .issue_cnt_r(a_icnt), .retire_cnt_r(a_rcnt), .aggregate_cnt_r(a_agg),
        .hwm_r(a_hwm), .err_ovf_r(a_ovf), .err_udf_r(a_udf), .busy(a_busy));

    latency_mon #(.W(4), .N_CH(2), .P(2), .SAT(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .issue(issue), .retire(retire), .clear(clear), .freeze(freeze),
        .pending_r(b_pend), .issue_cnt_r(b_icnt), .retire_cnt_r(b_rcnt), .aggregate_cnt_r(b_agg),
        .hwm_r(b_hwm), .err_ovf_r(b_ovf), .err_udf_r(b_udf), .busy(b_busy));

    latency_mon #(.W(4), .N_CH(2), .P(2), .SAT(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .issue(issue), .retire(retire), .clear(clear), .freeze(freeze),
        .pending_r(c_pend), .issue_cnt_r(c_icnt), .retire_cnt_r(c_rcnt), .aggregate_cnt_r(c_agg),
        .hwm_r(c_hwm), .err_ovf_r(c_ovf), .err_udf_r(c_udf), .busy(c_busy));

    function automatic longint stat_add(int d, longint a, longint b);
        longint lim = (64'sd1 <<< cfg_w[d]) - 64'sd1;
        longint s = a + b;
        if (cfg_sat[d] != 0 && s > lim) return lim;
        return s % (lim + 64'sd1);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++)
            for (int f = 0; f < NF; f++)
                for (int c = 0; c < 2; c++) mdl[d][f][c] = 0;
    endtask

    task automatic model_step(logic [1:0] iss, logic [1:0] ret, logic clr, logic frz);
        longint p, pmax;
        bit ia, ra;
        if (clr) begin
            model_reset();
            return;
        end
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < 2; c++) begin
                p    = mdl[d][F_PEND][c];
                pmax = (64'sd1 <<< cfg_p[d]) - 64'sd1;
                ia   = iss[c] && !(p == pmax && !ret[c]);
                ra   = ret[c] && (p != 0 || iss[c]);
                if (iss[c] && !ia) mdl[d][F_OVF][c] = 1;
                if (ret[c] && !ra) mdl[d][F_UDF][c] = 1;
                p = p + longint'(ia) - longint'(ra);
                mdl[d][F_PEND][c] = p;
                if (p > mdl[d][F_HWM][c]) mdl[d][F_HWM][c] = p;
                if (!frz) begin
                    mdl[d][F_ICNT][c] = stat_add(d, mdl[d][F_ICNT][c], longint'(ia));
                    mdl[d][F_RCNT][c] = stat_add(d, mdl[d][F_RCNT][c], longint'(ra));
                    mdl[d][F_AGG][c]  = stat_add(d, mdl[d][F_AGG][c], p);
                end
            end
        end
    endtask

    function automatic longint get_act(int d, int f, int c);
        case (d)
            0: case (f)
                F_PEND: return longint'(a_pend[c]);
                F_ICNT: return longint'(a_icnt[c]);
                F_RCNT: return longint'(a_rcnt[c]);
                F_AGG:  return longint'(a_agg[c]);
                F_HWM:  return longint'(a_hwm[c]);
                F_OVF:  return longint'(a_ovf[c]);
                default: return longint'(a_udf[c]);
            endcase
            1: case (f)
                F_PEND: return longint'(b_pend[c]);
                F_ICNT: return longint'(b_icnt[c]);
                F_RCNT: return longint'(b_rcnt[c]);
                F_AGG:  return longint'(b_agg[c]);
                F_HWM:  return longint'(b_hwm[c]);
                F_OVF:  return longint'(b_ovf[c]);
                default: return longint'(b_udf[c]);
            endcase
            default: case (f)
                F_PEND: return longint'(c_pend[c]);
                F_ICNT: return longint'(c_icnt[c]);
                F_RCNT: return longint'(c_rcnt[c]);
                F_AGG:  return longint'(c_agg[c]);
                F_HWM:  return longint'(c_hwm[c]);
                F_OVF:  return longint'(c_ovf[c]);
                default: return longint'(c_udf[c]);
            endcase
        endcase
    endfunction

    function automatic longint get_busy(int d);
        case (d)
            0: return longint'(a_busy);
            1: return longint'(b_busy);
            default: return longint'(c_busy);
        endcase
    endfunction

    task automatic check_val(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(string tag);
        longint exp_busy;
        for (int d = 0; d < ND; d++) begin
            for (int f = 0; f < NF; f++)
                for (int c = 0; c < 2; c++)
                    check_val($sformatf("%s dut%0d %s ch%0d", tag, d, fname[f], c), get_act(d, f, c), mdl[d][f][c]);
            exp_busy = (mdl[d][F_PEND][0] != 0 || mdl[d][F_PEND][1] != 0) ? 1 : 0;
            check_val($sformatf("%s dut%0d busy", tag, d), get_busy(d), exp_busy);
        end
    endtask

    task automatic cycle(logic [1:0] iss, logic [1:0] ret, logic clr, logic frz, string tag);
        issue  = iss;
        retire = ret;
        clear  = clr;
        freeze = frz;
        @(posedge clk);
        model_step(iss, ret, clr, frz);
        #1;
        check_all(tag);
    endtask

    typedef struct {
        logic [1:0] iss;
        logic [1:0] ret;
        int         e_pend0;
        int         e_agg0;
        int         e_icnt0;
        int         e_rcnt0;
        int         e_busy;
    } vec_t;

    vec_t tbl[9];
    int   pi, pr;

    initial begin
        rst_n = 1'b0; issue = 2'b00; retire = 2'b00; clear = 1'b0; freeze = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Ch0 issue/issue/idle/retire/idle/retire, then three zero-latency pass-throughs.
        tbl[0] = '{2'b01, 2'b00, 1, 1, 1, 0, 1};
        tbl[1] = '{2'b01, 2'b00, 2, 3, 2, 0, 1};
        tbl[2] = '{2'b00, 2'b00, 2, 5, 2, 0, 1};
        tbl[3] = '{2'b00, 2'b01, 1, 6, 2, 1, 1};
        tbl[4] = '{2'b00, 2'b00, 1, 7, 2, 1, 1};
        tbl[5] = '{2'b00, 2'b01, 0, 7, 2, 2, 0};
        tbl[6] = '{2'b01, 2'b01, 0, 7, 3, 3, 0};
        tbl[7] = '{2'b01, 2'b01, 0, 7, 4, 4, 0};
        tbl[8] = '{2'b01, 2'b01, 0, 7, 5, 5, 0};
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].iss, tbl[i].ret, 1'b0, 1'b0, $sformatf("tbl%0d", i));
            check_val($sformatf("tbl%0d pending0", i), longint'(a_pend[0]), tbl[i].e_pend0);
            check_val($sformatf("tbl%0d aggregate0", i), longint'(a_agg[0]), tbl[i].e_agg0);
            check_val($sformatf("tbl%0d issue_cnt0", i), longint'(a_icnt[0]), tbl[i].e_icnt0);
            check_val($sformatf("tbl%0d retire_cnt0", i), longint'(a_rcnt[0]), tbl[i].e_rcnt0);
            check_val($sformatf("tbl%0d busy", i), longint'(a_busy), tbl[i].e_busy);
        end
        check_val("t1 hwm0", longint'(a_hwm[0]), 2);
        check_val("t2 err_udf0", longint'(a_udf[0]), 0);

        // Overflow then underflow on ch1 of the P=2 instance, then clear.
        for (int i = 0; i < 4; i++) begin
            cycle(2'b10, 2'b00, 1'b0, 1'b0, "t3_iss");
            if (i == 2) check_val("t3 ovf before 4th", longint'(b_ovf[1]), 0);
        end
        check_val("t3 pending sat", longint'(b_pend[1]), 3);
        check_val("t3 issue_cnt", longint'(b_icnt[1]), 3);
        check_val("t3 err_ovf", longint'(b_ovf[1]), 1);
        for (int i = 0; i < 3; i++) cycle(2'b00, 2'b10, 1'b0, 1'b0, "t3_ret");
        check_val("t3 udf before", longint'(b_udf[1]), 0);
        cycle(2'b00, 2'b10, 1'b0, 1'b0, "t3_udf");
        check_val("t3 err_udf", longint'(b_udf[1]), 1);
        cycle(2'b00, 2'b00, 1'b1, 1'b0, "t3_clr");
        check_val("t3 ovf cleared", longint'(b_ovf[1]), 0);
        check_val("t3 udf cleared", longint'(b_udf[1]), 0);

        // Twenty cycles of occupancy 1 into 4-bit aggregates.
        cycle(2'b01, 2'b00, 1'b0, 1'b0, "t4_iss");
        for (int i = 0; i < 19; i++) cycle(2'b00, 2'b00, 1'b0, 1'b0, "t4_idle");
        check_val("t4 sat aggregate", longint'(c_agg[0]), 15);
        check_val("t4 wrap aggregate", longint'(b_agg[0]), 4);
        check_val("t4 w8 aggregate", longint'(a_agg[0]), 20);

        // Freeze with two outstanding and one issue during the freeze.
        cycle(2'b00, 2'b00, 1'b1, 1'b0, "t5_clr");
        cycle(2'b01, 2'b00, 1'b0, 1'b0, "t5_iss");
        cycle(2'b01, 2'b00, 1'b0, 1'b0, "t5_iss");
        cycle(2'b01, 2'b00, 1'b0, 1'b1, "t5_frz");
        for (int i = 0; i < 4; i++) cycle(2'b00, 2'b00, 1'b0, 1'b1, "t5_frz");
        check_val("t5 aggregate held", longint'(a_agg[0]), 3);
        check_val("t5 issue_cnt held", longint'(a_icnt[0]), 2);
        check_val("t5 pending", longint'(a_pend[0]), 3);
        check_val("t5 hwm", longint'(a_hwm[0]), 3);
        cycle(2'b00, 2'b00, 1'b0, 1'b0, "t5_resume");
        check_val("t5 aggregate resumed", longint'(a_agg[0]), 6);

        // Async reset mid-cycle with five outstanding, then clear with strobes.
        cycle(2'b00, 2'b00, 1'b1, 1'b0, "t6_clr");
        for (int i = 0; i < 5; i++) cycle(2'b01, 2'b00, 1'b0, 1'b0, "t6_iss");
        check_val("t6 pending before reset", longint'(a_pend[0]), 5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(2'b01, 2'b00, 1'b0, 1'b0, "t6_first");
        check_val("t6 first after reset", longint'(a_pend[0]), 1);
        cycle(2'b11, 2'b00, 1'b0, 1'b0, "t6_iss");
        cycle(2'b11, 2'b11, 1'b1, 1'b0, "t6_clrstrobe");
        check_val("t6 clear pending", longint'(a_pend[0]), 0);
        check_val("t6 clear udf", longint'(a_udf), 0);

        // Random traffic with phases favouring build-up or drain.
        for (int i = 0; i < 3000; i++) begin
            pi = ((i / 150) % 2 == 0) ? 70 : 30;
            pr = 100 - pi;
            cycle({($urandom_range(0, 99) < pi), ($urandom_range(0, 99) < pi)},
                  {($urandom_range(0, 99) < pr), ($urandom_range(0, 99) < pr)},
                  ($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
